// File: rtl/riscv_pkg.sv
// Shared opcode constants and redirect FSM state type for the branch redirect controller.
package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redir_state_t;

    function automatic logic is_ctrl_opcode(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage resolution inputs and fetch-side redirect/flush/counter outputs of the redirect controller.
interface branch_redirect_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic             ex_br_taken;
  logic [XLEN-1:0]  ex_target;
  logic             pipe_stall;
  logic             fetch_ready;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_if;
  logic             flush_id;
  logic             misalign_err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output ex_valid, ex_opcode, ex_br_taken, ex_target, pipe_stall, fetch_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id, misalign_err, branch_cnt, taken_cnt
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_br_taken, ex_target, pipe_stall, fetch_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id, misalign_err, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter for the per-core branch performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // next count: clear wins, otherwise increment unless already all-ones
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns resolved taken control-flow instructions into a held PC redirect plus IF/ID flushes,
// and counts resolved/taken branches while not already redirecting.
module branch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_redirect_ctrl_if.slave  bus
);
  redir_state_t    state_d;
  redir_state_t    state_q;
  logic [XLEN-1:0] redirect_pc_d;
  logic [XLEN-1:0] redirect_pc_q;
  logic            misalign_d;
  logic            misalign_q;
  logic            is_ctrl_s;
  logic            taken_s;
  logic            aligned_s;
  logic            in_idle_s;
  logic            branch_inc_s;
  logic            taken_inc_s;
  logic [CNT_W-1:0] branch_cnt_s;
  logic [CNT_W-1:0] taken_cnt_s;

  assign is_ctrl_s    = bus.ex_valid && is_ctrl_opcode(bus.ex_opcode) && !bus.pipe_stall;
  assign taken_s      = is_ctrl_s && bus.ex_br_taken;
  assign aligned_s    = (bus.ex_target[1:0] == 2'b00);
  assign in_idle_s    = (state_q == IDLE);
  // Anything resolved while a redirect is pending is on the wrong path.
  assign branch_inc_s = in_idle_s && is_ctrl_s;
  assign taken_inc_s  = in_idle_s && taken_s;

  // next state, target latch and misalign pulse
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    misalign_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (taken_s && aligned_s) begin
          state_d       = REDIRECT;
          redirect_pc_d = bus.ex_target;
        end else if (taken_s) begin
          misalign_d    = 1'b1;
        end else begin
          state_d       = IDLE;
        end
      end
      REDIRECT: begin
        if (bus.fetch_ready) begin
          state_d = IDLE;
        end else begin
          state_d = REDIRECT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, redirect target and misalign registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_pc_q <= {XLEN{1'b0}};
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_inc_s),
    .clear (1'b0),
    .count (branch_cnt_s)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (taken_inc_s),
    .clear (1'b0),
    .count (taken_cnt_s)
  );

  // Redirect fires the same cycle fetch accepts it; flushes track the state directly.
  assign bus.redirect_valid = (state_q == REDIRECT) && bus.fetch_ready;
  assign bus.flush_if       = (state_q == REDIRECT);
  assign bus.flush_id       = (state_q == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.misalign_err   = misalign_q;
  assign bus.branch_cnt     = branch_cnt_s;
  assign bus.taken_cnt      = taken_cnt_s;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: directed vector table, reset/saturation sequences and random stimulus
// against a queue-based reference model of the redirect controller.
module tb_branch_redirect_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;
  localparam logic [6:0] B_OP    = 7'b1100011;
  localparam logic [6:0] JAL_OP  = 7'b1101111;
  localparam logic [6:0] JALR_OP = 7'b1100111;
  localparam logic [6:0] ALU_OP  = 7'b0010011;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  branch_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pending redirect targets and counters
  logic [31:0] pend[$];
  logic [31:0] m_pc;
  logic        m_mis;
  int          m_bc;
  int          m_tc;

  typedef struct {
    logic v; logic [6:0] opc; logic tk; logic [31:0] tgt; logic st; logic fr;
    logic rv; logic [31:0] pc; logic fl; logic mis; int bc; int tc;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic v, input logic [6:0] opc, input logic tk,
                              input logic [31:0] tgt, input logic st, input logic fr,
                              input logic rv, input logic [31:0] pc, input logic fl,
                              input logic mis, input int bc, input int tc);
    vec_t r;
    r.v = v; r.opc = opc; r.tk = tk; r.tgt = tgt; r.st = st; r.fr = fr;
    r.rv = rv; r.pc = pc; r.fl = fl; r.mis = mis; r.bc = bc; r.tc = tc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_pc  = 32'h0;
    m_mis = 1'b0;
    m_bc  = 0;
    m_tc  = 0;
  endtask

  task automatic model_update();
    logic ctrl;
    ctrl = bus.ex_valid && !bus.pipe_stall &&
           (bus.ex_opcode == B_OP || bus.ex_opcode == JAL_OP || bus.ex_opcode == JALR_OP);
    if (pend.size() == 0) begin
      if (ctrl) m_bc = (m_bc >= CMAX) ? CMAX : m_bc + 1;
      if (ctrl && bus.ex_br_taken) m_tc = (m_tc >= CMAX) ? CMAX : m_tc + 1;
      m_mis = ctrl && bus.ex_br_taken && (bus.ex_target % 4 != 0);
      if (ctrl && bus.ex_br_taken && (bus.ex_target % 4 == 0)) begin
        pend.push_back(bus.ex_target);
        m_pc = bus.ex_target;
      end
    end else begin
      m_mis = 1'b0;
      if (bus.fetch_ready) void'(pend.pop_front());
    end
  endtask

  task automatic check_model();
    logic busy;
    busy = (pend.size() != 0);
    chk("redirect_valid", {31'h0, bus.redirect_valid}, {31'h0, busy && bus.fetch_ready});
    chk("redirect_pc", bus.redirect_pc, m_pc);
    chk("flush_if", {31'h0, bus.flush_if}, {31'h0, busy});
    chk("flush_id", {31'h0, bus.flush_id}, {31'h0, busy});
    chk("misalign_err", {31'h0, bus.misalign_err}, {31'h0, m_mis});
    chk("branch_cnt", {28'h0, bus.branch_cnt}, m_bc);
    chk("taken_cnt", {28'h0, bus.taken_cnt}, m_tc);
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic tk,
                       input logic [31:0] tgt, input logic st, input logic fr);
    bus.ex_valid    = v;
    bus.ex_opcode   = opc;
    bus.ex_br_taken = tk;
    bus.ex_target   = tgt;
    bus.pipe_stall  = st;
    bus.fetch_ready = fr;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic v, input logic [6:0] opc, input logic tk,
                      input logic [31:0] tgt, input logic st, input logic fr);
    drive(v, opc, tk, tgt, st, fr);
    @(negedge clk);
    check_model();
    advance();
  endtask

  initial begin
    logic [31:0] rtgt;
    logic [6:0]  ropc;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 7'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    reset = 1'b0;

    // rows: inputs | outputs observed mid-cycle while those inputs are applied
    tbl[0]  = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 0, 0);
    tbl[1]  = mk(1'b1, B_OP,    1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 0, 0);
    tbl[2]  = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1, 1);
    tbl[3]  = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1, 1);
    tbl[4]  = mk(1'b1, B_OP,    1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1, 1);
    tbl[5]  = mk(1'b1, B_OP,    1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 2, 2);
    tbl[6]  = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 2, 2);
    tbl[7]  = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 2, 2);
    tbl[8]  = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 2, 2);
    tbl[9]  = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 2, 2);
    tbl[10] = mk(1'b1, B_OP,    1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 2, 2);
    tbl[11] = mk(1'b1, B_OP,    1'b0, 32'h400, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 2, 2);
    tbl[12] = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 3, 2);
    tbl[13] = mk(1'b1, JALR_OP, 1'b1, 32'h102, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 3, 2);
    tbl[14] = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 4, 3);
    tbl[15] = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 4, 3);
    tbl[16] = mk(1'b1, JAL_OP,  1'b0, 32'h500, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 4, 3);
    tbl[17] = mk(1'b1, ALU_OP,  1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 5, 3);
    tbl[18] = mk(1'b0, B_OP,    1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 5, 3);
    tbl[19] = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 5, 3);
    tbl[20] = mk(1'b0, B_OP,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 5, 3);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].opc, tbl[i].tk, tbl[i].tgt, tbl[i].st, tbl[i].fr);
      @(negedge clk);
      check_model();
      chk($sformatf("tbl%0d_rv", i), {31'h0, bus.redirect_valid}, {31'h0, tbl[i].rv});
      chk($sformatf("tbl%0d_pc", i), bus.redirect_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_flush", i), {30'h0, bus.flush_if, bus.flush_id}, {30'h0, tbl[i].fl, tbl[i].fl});
      chk($sformatf("tbl%0d_mis", i), {31'h0, bus.misalign_err}, {31'h0, tbl[i].mis});
      chk($sformatf("tbl%0d_bc", i), {28'h0, bus.branch_cnt}, tbl[i].bc);
      chk($sformatf("tbl%0d_tc", i), {28'h0, bus.taken_cnt}, tbl[i].tc);
      advance();
    end

    // saturation: 20 taken branches, each followed by its redirect cycle
    for (int i = 0; i < 20; i++) begin
      step(1'b1, JAL_OP, 1'b1, 32'h1000 + 32'(i) * 32'd4, 1'b0, 1'b1);
      step(1'b0, B_OP, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("sat_branch_cnt", {28'h0, bus.branch_cnt}, 32'd15);
    chk("sat_taken_cnt", {28'h0, bus.taken_cnt}, 32'd15);

    // reset while a redirect is held by a busy icache
    @(posedge clk);
    #1;
    step(1'b1, B_OP, 1'b1, 32'h800, 1'b0, 1'b0);
    drive(1'b0, B_OP, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("pre_reset_rv", {31'h0, bus.redirect_valid}, 32'h1);
    chk("pre_reset_pc", bus.redirect_pc, 32'h800);
    reset = 1'b1;
    #1;
    chk("rst_rv", {31'h0, bus.redirect_valid}, 32'h0);
    chk("rst_flush", {30'h0, bus.flush_if, bus.flush_id}, 32'h0);
    chk("rst_pc", bus.redirect_pc, 32'h0);
    chk("rst_mis", {31'h0, bus.misalign_err}, 32'h0);
    chk("rst_cnt", {24'h0, bus.branch_cnt, bus.taken_cnt}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, B_OP, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, B_OP, 1'b0, 32'h0, 1'b0, 1'b1);

    // random blocks, each starting from reset so counters are not always saturated
    for (int blk = 0; blk < 4; blk++) begin
      reset = 1'b1;
      #2;
      model_reset();
      check_model();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 60; c++) begin
        case ($urandom_range(0, 3))
          0:       ropc = B_OP;
          1:       ropc = JAL_OP;
          2:       ropc = JALR_OP;
          default: ropc = 7'($urandom);
        endcase
        rtgt = $urandom;
        if ($urandom_range(0, 3) != 0) rtgt[1:0] = 2'b00;
        step(($urandom_range(0, 4) != 0), ropc, ($urandom_range(0, 2) != 0), rtgt,
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the front-end response to a resolved control-flow instruction in the execute stage. It takes the branch-condition result (br_taken), opcode and target, then drives the PC-select/redirect and IF/ID flush signals. It holds the redirect while the instruction cache is busy and counts resolved and taken branches for the per-core performance counters. There is one instance per core, between the EX-stage branch-condition unit and the fetch stage/icache port.

Parameters:
XLEN, 32, data/address width
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  EX stage holds a valid, non-bubble instruction
ex_opcode  in  7  EX instruction opcode
ex_br_taken  in  1  branch-condition unit result, valid with ex_valid
ex_target  in  XLEN  computed branch/jump target
pipe_stall  in  1  pipeline frozen (dcache miss); EX not advancing
fetch_ready  in  1  fetch/icache can accept a new PC this cycle
redirect_valid  out  1  load redirect_pc into PC this cycle
redirect_pc  out  XLEN  registered target
flush_if  out  1  squash IF/ID register
flush_id  out  1  squash ID/EX register
misalign_err  out  1  one-cycle pulse, taken target not word aligned
branch_cnt  out  CNT_W  resolved control-flow instructions
taken_cnt  out  CNT_W  taken control-flow instructions

Behaviour:
- Control opcodes: B = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111.
- is_ctrl = ex_valid && opcode is one of the control opcodes && !pipe_stall.
- event = is_ctrl && ex_br_taken && ex_target[1:0]==0.
- Reset (async): state=IDLE; redirect_pc=0; every 1-bit output =0; both counters =0.
- FSM state IDLE:
  - On event: latch redirect_pc=ex_target; go to REDIRECT.
  - If is_ctrl && ex_br_taken && ex_target[1:0]!=0: pulse misalign_err next cycle; no redirect; stay in IDLE.
- FSM state REDIRECT:
  - flush_if=flush_id=1 every cycle in this state.
  - If fetch_ready: redirect_valid=1 for exactly this cycle, then go to IDLE.
  - Else: hold redirect_pc; redirect_valid=0; stay in REDIRECT; flushes stay asserted.
- Latency: event in cycle N -> earliest redirect_valid in N+1. Each fetch_ready-low cycle adds one cycle.
- Only flush_if and flush_id are combinational from state. redirect_valid is state && fetch_ready. All other outputs are registered.
- Events arriving while in REDIRECT are wrong-path and are ignored: no latch, no count.
- pipe_stall=1 suppresses event and counting, whatever the other inputs.
- Counters update only in IDLE:
  - branch_cnt += 1 per is_ctrl.
  - taken_cnt += 1 per is_ctrl && ex_br_taken; misaligned taken branches are included.
  - Both counters saturate at all-ones; there is no wrap-around.
- JAL/JALR with ex_br_taken=0 is counted in branch_cnt only; no redirect.
- Non-control opcode with ex_br_taken=1: ignored.
- Reset asserted in REDIRECT: the pending redirect is dropped immediately and every output returns to its reset value.

Decomposition:
- Shared package (riscv_pkg): opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR; FSM enum typedef redir_state_t {IDLE, REDIRECT}.
- One natural sub-module: sat_counter (parameter CNT_W, inputs inc and clear), instantiated twice.

Test Plan:
- BEQ taken: ex_valid=1, opcode=1100011, br_taken=1, target=0x100, fetch_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x100, flush_if=flush_id=1; branch_cnt=1, taken_cnt=1.
- Icache busy: same event with fetch_ready=0 for 3 cycles -> flushes held 3 cycles, redirect_pc stays 0x100; redirect_valid=1 on the cycle fetch_ready rises, then IDLE.
- Wrong-path suppression: second taken branch (target 0x200) presented while in REDIRECT -> ignored; redirect_pc stays 0x100; counters unchanged.
- Stall and not-taken: pipe_stall=1 with taken branch -> no redirect, no count. Not-taken BNE -> branch_cnt+1 only, no flush.
- Misalign: taken JALR with target=0x102 -> misalign_err pulses one cycle, no redirect_valid; taken_cnt+1.
- Saturation/reset: CNT_W=4, 20 taken branches -> both counters =15. Assert reset mid-REDIRECT -> all outputs 0 in the same cycle, no redirect issued.
